uart_fifo_ctl: RTL and testbench
================================

Name: uart_fifo_ctl

Overview:
- 8N1 UART controller: byte-wide write port feeding an internal synchronous TX FIFO, drained automatically into a UART serializer; independent UART deserializer on the receive line.
- Sits between on-chip byte producers/consumers and the board serial pins.
- tx may be looped back to rx for self-test.

Parameters:
- CLK_FREQ, 100000000, clk frequency in Hz.
- BAUD, 115200, line rate in bit/s. CLKS_PER_BIT = round(CLK_FREQ/BAUD); BAUD=4000000 gives 25.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2 or more.

Ports:
- clk, in, 1, single system clock; all logic on its rising edge.
- rst, in, 1, reset; synchronous, active-high.
- wr_en, in, 1, push din into TX FIFO.
- din, in, 8, byte to transmit.
- full, out, 1, TX FIFO full.
- empty, out, 1, TX FIFO empty.
- tx_busy, out, 1, serializer mid-frame or FIFO non-empty.
- uart_tx, out, 1, serial output; idle high.
- uart_rx, in, 1, serial input; asynchronous.
- rx_data, out, 8, last good received byte; held until the next good frame.
- rx_valid, out, 1, one-cycle pulse when rx_data updates.
- rx_frame_err, out, 1, one-cycle pulse when a stop bit is sampled low.

Behaviour:
- Reset values: uart_tx=1, FIFO flushed (empty=1, full=0), tx_busy=0, rx_data=0, rx_valid=0, rx_frame_err=0; both FSMs return to IDLE.
- Reset asserted mid-frame aborts the frame; uart_tx is high on the cycle after the reset edge.
- FIFO:
  - Write with full=1 is dropped, even if a pop occurs in the same cycle.
  - Pop only when empty=0.
  - Simultaneous push and pop when not full and not empty: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - full and empty are registered and reflect the count after each edge.
  - Pop data is available one cycle after the pop, flagged by an internal valid.
- TX FSM: IDLE -> FETCH -> START -> DATA -> STOP -> IDLE.
  - IDLE: if empty=0, pop and go to FETCH.
  - FETCH: latch the byte when valid is high.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each for CLKS_PER_BIT cycles.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles.
  - Back-to-back frames: the next start bit begins no more than 3 clocks after the previous stop bit ends.
  - A write to an empty, idle block produces the start bit within 4 clocks of the wr_en edge.
- RX path: uart_rx passes through a 2-flop synchronizer.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a synchronized falling edge goes to START.
  - START: sample at CLKS_PER_BIT/2. If the line is high, treat as a glitch and return to IDLE with no outputs.
  - DATA: sample each data bit at mid-bit (every CLKS_PER_BIT cycles), shifting LSB first.
  - STOP: sample at mid-bit. If high, update rx_data and pulse rx_valid; if low, pulse rx_frame_err and leave rx_data unchanged.
  - Then return to IDLE and rearm immediately, so back-to-back frames are accepted.
- Baud counters are ceil(log2(CLKS_PER_BIT)) bits wide and reload to 0 at CLKS_PER_BIT-1.

Decomposition:
- Package uart_pkg:
  - TX/RX state enums.
  - localparams CLKS_PER_BIT, cnt width, DATA_W=8.
- One sub-module, sync_fifo (8-bit, depth FIFO_DEPTH, outputs full/empty/valid).
- TX and RX FSMs live in uart_fifo_ctl.

Test Plan:
- Basic transmit: CLK_FREQ=100M, BAUD=4M; rst, then write 0x41 once -> uart_tx frame low, 1,0,0,0,0,0,1,0, high, each bit 25 cycles; looped back, rx_valid pulses once with rx_data=0x41.
- Burst: write 0x00..0x16 on consecutive cycles -> full asserts; no more than FIFO_DEPTH+1 bytes accepted; loopback receives an exact ascending prefix with no duplicates or gaps; tx_busy falls after the last stop bit.
- Glitch reject: drive uart_rx low for 5 cycles, then high -> no rx_valid, no rx_frame_err.
- Framing error: drive a frame of 0x5A with the stop bit low -> rx_frame_err pulses once, rx_valid stays 0, rx_data unchanged.
- Reset mid-frame: assert rst during the DATA bits of byte 0xA5 with 3 bytes queued -> uart_tx=1 next cycle, empty=1, no further frames sent.
- FIFO boundaries: with tx held off by rst release timing, push until full, pop to empty -> full/empty toggle at exact counts; a write while full is dropped; pointer wrap is exercised across 2×FIFO_DEPTH bytes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART controller.
// Baud-derived constants are computed per instance from the top-level parameters.
package uart_pkg;

  localparam int DATA_W = 8;

  function automatic int calc_clks_per_bit(input longint clk_freq, input longint baud);
    return int'((clk_freq + baud / 2) / baud);
  endfunction

  function automatic int calc_cnt_w(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

  // Defaults for a 100 MHz clock at 115200 baud.
  localparam int CLKS_PER_BIT = calc_clks_per_bit(100000000, 115200);
  localparam int CNT_W        = calc_cnt_w(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_FETCH,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_fifo_ctl_fifo.sv
// Synchronous FIFO with registered full/empty and a one-cycle read latency.
// Read data appears the cycle after a pop, qualified by valid.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          full_reg, empty_reg, valid_reg;
  logic [W-1:0]  dout_reg;
  logic          push, pop;

  // A write while full is dropped regardless of a same-cycle pop.
  assign push = wr_en && !full_reg;
  assign pop  = rd_en && !empty_reg;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (!push && pop) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      dout_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      valid_reg  <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= (count_next == (AW+1)'(DEPTH));
      empty_reg <= (count_next == '0);
      valid_reg <= pop;
    end
  end

  assign dout  = dout_reg;
  assign valid = valid_reg;
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/uart_fifo_ctl.sv
// 8N1 UART: buffered transmitter draining a TX FIFO, plus an independent receiver.
// Both directions share one baud period derived from CLK_FREQ/BAUD.
module uart_fifo_ctl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic              tx_busy,
  output logic              uart_tx,
  input  logic              uart_rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_frame_err
);

  localparam int BIT_CLKS = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW       = calc_cnt_w(BIT_CLKS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);

  logic              fifo_rd, fifo_valid, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .din   (din),
    .rd_en (fifo_rd),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  tx_state_t         tx_state_reg;
  logic [CW-1:0]     tx_cnt_reg;
  logic [2:0]        tx_bit_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic              uart_tx_reg;

  assign fifo_rd = (tx_state_reg == TX_IDLE) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      uart_tx_reg  <= 1'b1;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          if (!fifo_empty) tx_state_reg <= TX_FETCH;
        end
        TX_FETCH: begin
          if (fifo_valid) begin
            tx_shift_reg <= fifo_dout;
            tx_cnt_reg   <= '0;
            uart_tx_reg  <= 1'b0;
            tx_state_reg <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            uart_tx_reg  <= tx_shift_reg[0];
            tx_shift_reg <= tx_shift_reg >> 1;
            tx_state_reg <= TX_DATA;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg <= '0;
            if (tx_bit_reg == 3'd7) begin
              uart_tx_reg  <= 1'b1;
              tx_state_reg <= TX_STOP;
            end else begin
              uart_tx_reg  <= tx_shift_reg[0];
              tx_shift_reg <= tx_shift_reg >> 1;
              tx_bit_reg   <= tx_bit_reg + 3'd1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_state_reg <= TX_IDLE;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  assign uart_tx = uart_tx_reg;
  assign full    = fifo_full;
  assign empty   = fifo_empty;
  assign tx_busy = (tx_state_reg != TX_IDLE) || !fifo_empty;

  rx_state_t         rx_state_reg;
  logic              rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [CW-1:0]     rx_cnt_reg;
  logic [2:0]        rx_bit_reg;
  logic [DATA_W-1:0] rx_shift_reg, rx_data_reg;
  logic              rx_valid_reg, rx_frame_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg      <= 1'b1;
      rx_sync_reg      <= 1'b1;
      rx_prev_reg      <= 1'b1;
      rx_state_reg     <= RX_IDLE;
      rx_cnt_reg       <= '0;
      rx_bit_reg       <= '0;
      rx_shift_reg     <= '0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rx_frame_err_reg <= 1'b0;
    end else begin
      rx_meta_reg      <= uart_rx;
      rx_sync_reg      <= rx_meta_reg;
      rx_prev_reg      <= rx_sync_reg;
      rx_valid_reg     <= 1'b0;
      rx_frame_err_reg <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_prev_reg && !rx_sync_reg) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= RX_START;
          end
        end
        RX_START: begin
          // A line already back high at mid start bit was a glitch.
          if (rx_cnt_reg == HALF_LAST) begin
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[DATA_W-1:1]};
            if (rx_bit_reg == 3'd7) begin
              rx_state_reg <= RX_STOP;
            end else begin
              rx_bit_reg <= rx_bit_reg + 3'd1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= RX_IDLE;
            if (rx_sync_reg) begin
              rx_data_reg  <= rx_shift_reg;
              rx_valid_reg <= 1'b1;
            end else begin
              rx_frame_err_reg <= 1'b1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  assign rx_data      = rx_data_reg;
  assign rx_valid     = rx_valid_reg;
  assign rx_frame_err = rx_frame_err_reg;

endmodule

// File: tb/tb_uart_fifo_ctl.sv
// Directed bench for uart_fifo_ctl at 100 MHz / 4 Mbaud (25 clocks per bit).
// The receiver is fed either from uart_tx (loopback) or from a driven line.
module tb_uart_fifo_ctl;

  localparam int CPB = 25;

  logic       clk = 1'b0;
  logic       rst, wr_en, uart_rx, rx_drive, loop_en;
  logic [7:0] din;
  logic       full, empty, tx_busy, uart_tx, rx_valid, rx_frame_err;
  logic [7:0] rx_data;

  int n_pass = 0;
  int n_fail = 0;
  int n_checks = 0;
  logic [7:0] rx_q[$];
  int err_cnt = 0;

  int t, q0, e0, lows;
  logic [7:0] cap;
  logic stop_bit;

  always #5 clk = ~clk;

  assign uart_rx = loop_en ? uart_tx : rx_drive;

  uart_fifo_ctl #(
    .CLK_FREQ   (100000000),
    .BAUD       (4000000),
    .FIFO_DEPTH (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .full         (full),
    .empty        (empty),
    .tx_busy      (tx_busy),
    .uart_tx      (uart_tx),
    .uart_rx      (uart_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (rx_frame_err) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_drive = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_drive = b[i];
      repeat (CPB) tick();
    end
    rx_drive = stop;
    repeat (CPB) tick();
    rx_drive = 1'b1;
    repeat (30) tick();
  endtask

  // n consecutive writes starting with an empty, idle block: byte 0 is popped
  // at once, so 17 bytes are accepted and the rest are dropped.
  task automatic burst(input string tag, input logic [7:0] b0, input int n);
    int qs, tw, bad;
    qs = rx_q.size();
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      din   = b0 + 8'(i);
      tick();
      if (i == 15) check({tag, "_full_at_15"}, {31'd0, full}, 32'd0);
      if (i == 16) check({tag, "_full_at_16"}, {31'd0, full}, 32'd1);
    end
    wr_en = 1'b0;
    check({tag, "_full_after_drops"}, {31'd0, full}, 32'd1);
    tw = 0;
    while (full === 1'b1 && tw < 400) begin tick(); tw++; end
    check({tag, "_rx_at_full_fall"}, rx_q.size() - qs, 32'd1);
    tw = 0;
    while (empty === 1'b0 && tw < 6000) begin tick(); tw++; end
    check({tag, "_rx_at_empty_rise"}, rx_q.size() - qs, 32'd16);
    tw = 0;
    while (tx_busy === 1'b1 && tw < 1000) begin tick(); tw++; end
    check({tag, "_busy_fall_in_time"}, {31'd0, (tw < 1000)}, 32'd1);
    check({tag, "_tx_idle_high"}, {31'd0, uart_tx}, 32'd1);
    repeat (5) tick();
    check({tag, "_rx_count"}, rx_q.size() - qs, 32'd17);
    bad = 0;
    for (int k = 0; k < 17; k++) begin
      if (qs + k >= rx_q.size() || rx_q[qs + k] !== b0 + 8'(k)) bad++;
    end
    check({tag, "_rx_sequence_errs"}, bad, 32'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; din = '0; rx_drive = 1'b1; loop_en = 1'b0;
    repeat (3) tick();
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic transmit of 0x41 with loopback.
    loop_en = 1'b1;
    q0 = rx_q.size();
    wr_en = 1'b1; din = 8'h41; tick(); wr_en = 1'b0;
    t = 0;
    while (uart_tx !== 1'b0 && t < 10) begin tick(); t++; end
    check("start_latency_ok", {31'd0, (t >= 1 && t <= 4)}, 32'd1);
    t = 0;
    while (uart_tx === 1'b0 && t < 100) begin tick(); t++; end
    check("start_bit_len", t, CPB);
    repeat (12) tick();
    for (int i = 0; i < 8; i++) begin
      cap[i] = uart_tx;
      repeat (CPB) tick();
    end
    stop_bit = uart_tx;
    check("tx_bits_0x41", {24'd0, cap}, 32'h41);
    check("tx_stop_bit", {31'd0, stop_bit}, 32'd1);
    t = 0;
    while (rx_q.size() == q0 && t < 100) begin tick(); t++; end
    repeat (40) tick();
    check("loop_rx_count", rx_q.size() - q0, 32'd1);
    check("loop_rx_byte", {24'd0, (rx_q.size() > q0) ? rx_q[q0] : 8'h00}, 32'h41);
    check("loop_rx_data_port", {24'd0, rx_data}, 32'h41);
    check("idle_tx_busy", {31'd0, tx_busy}, 32'd0);

    burst("burst", 8'h00, 23);

    // Glitch shorter than half a bit.
    loop_en = 1'b0;
    q0 = rx_q.size();
    e0 = err_cnt;
    rx_drive = 1'b0;
    repeat (5) tick();
    rx_drive = 1'b1;
    repeat (60) tick();
    check("glitch_no_valid", rx_q.size() - q0, 32'd0);
    check("glitch_no_err", err_cnt - e0, 32'd0);

    // Framing error, then a clean driven frame.
    send_rx(8'h5A, 1'b0);
    check("ferr_pulses", err_cnt - e0, 32'd1);
    check("ferr_no_valid", rx_q.size() - q0, 32'd0);
    check("ferr_rx_data_held", {24'd0, rx_data}, 32'h10);
    send_rx(8'hC3, 1'b1);
    check("drv_rx_count", rx_q.size() - q0, 32'd1);
    check("drv_rx_byte", {24'd0, (rx_q.size() > q0) ? rx_q[q0] : 8'h00}, 32'hC3);
    check("drv_no_new_err", err_cnt - e0, 32'd1);

    // Reset during the data bits of 0xA5 with three more bytes queued.
    wr_en = 1'b1;
    din = 8'hA5; tick();
    din = 8'h01; tick();
    din = 8'h02; tick();
    din = 8'h03; tick();
    wr_en = 1'b0;
    t = 0;
    while (uart_tx !== 1'b0 && t < 20) begin tick(); t++; end
    repeat (CPB + 60) tick();
    rst = 1'b1;
    tick();
    check("midrst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("midrst_empty", {31'd0, empty}, 32'd1);
    check("midrst_full", {31'd0, full}, 32'd0);
    check("midrst_tx_busy", {31'd0, tx_busy}, 32'd0);
    rst = 1'b0;
    lows = 0;
    repeat (400) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    check("midrst_no_more_frames", lows, 32'd0);

    // Two full rounds after reset push 34 bytes through, wrapping the pointers.
    loop_en = 1'b1;
    burst("wrap_a", 8'h80, 18);
    burst("wrap_b", 8'hC0, 18);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
